// File: rtl/debounce_bank.sv
// N-channel push-button conditioner: 2-flop synchroniser, stability-count debounce,
// press/release strobes and optional typematic auto-repeat per channel.
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] keyBounce,
  output logic [CHANNELS-1:0] key_state,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] key_repeat
);

  localparam int unsigned CntW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW  = $clog2(RepMax + 1);

  localparam logic             IdleLvl   = (ACTIVE_LOW != 0);
  localparam logic [CntW-1:0]  CntLast   = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0]  CntOne    = CntW'(1);
  localparam logic [RcntW-1:0] RepDelay  = RcntW'(REPEAT_DELAY);
  localparam logic [RcntW-1:0] RepPeriod = RcntW'(REPEAT_PERIOD);
  localparam logic [RcntW-1:0] RcntOne   = RcntW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StRepeat} rep_state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic            s1_q, s2_q, pressed;
    logic            state_q, press_q, release_q;
    logic [CntW-1:0] cnt_q;

    // Normalised so that 1 always means "pressed" regardless of board polarity.
    assign pressed = s2_q ^ IdleLvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= IdleLvl;
        s2_q      <= IdleLvl;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= keyBounce[i];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (pressed == state_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
          state_q   <= pressed;
          cnt_q     <= '0;
          press_q   <= pressed;
          release_q <= ~pressed;
        end else begin
          cnt_q <= cnt_q + CntOne;
        end
      end
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

    if (REPEAT_EN != 0) begin : g_rep
      rep_state_e       st_q, st_d;
      logic [RcntW-1:0] rcnt_q, rcnt_d;
      logic             rep;

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q   <= StIdle;
          rcnt_q <= '0;
        end else begin
          st_q   <= st_d;
          rcnt_q <= rcnt_d;
        end
      end

      // key_state is already low in the release strobe cycle, so release beats a due repeat.
      always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        rep    = 1'b0;
        unique case (st_q)
          StIdle: begin
            if (press_q) begin
              st_d   = StWait;
              rcnt_d = RcntOne;
            end
          end
          StWait: begin
            if (!state_q) begin
              st_d   = StIdle;
              rcnt_d = '0;
            end else if (rcnt_q == RepDelay) begin
              rep    = 1'b1;
              st_d   = StRepeat;
              rcnt_d = RcntOne;
            end else begin
              rcnt_d = rcnt_q + RcntOne;
            end
          end
          StRepeat: begin
            if (!state_q) begin
              st_d   = StIdle;
              rcnt_d = '0;
            end else if (rcnt_q == RepPeriod) begin
              rep    = 1'b1;
              rcnt_d = RcntOne;
            end else begin
              rcnt_d = rcnt_q + RcntOne;
            end
          end
          default: begin
            st_d   = StIdle;
            rcnt_d = '0;
          end
        endcase
      end

      assign key_repeat[i] = rep;
    end else begin : g_norep
      assign key_repeat[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: stimulus schedules expected strobes by cycle,
// a negedge monitor pops and compares whenever the DUT emits (or should emit) a strobe.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyBounce;
  logic [3:0] key_state, key_press, key_release, key_repeat;

  debounce_bank #(
    .CHANNELS     (4),
    .STABLE_CYCLES(4),
    .ACTIVE_LOW   (1),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keyBounce  (keyBounce),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  // Hand-derived timing for STABLE_CYCLES=4, DELAY=8, PERIOD=3.
  localparam int Lat    = 6;
  localparam int Delay  = 8;
  localparam int Period = 3;

  typedef struct packed {
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
  } ev_t;

  ev_t exp_sb[int];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;
  int  k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] rp);
    ev_t e;
    e = '{pr: pr, rl: rl, rp: rp};
    if (exp_sb.exists(c)) e = e | exp_sb[c];
    exp_sb[c] = e;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: compares emitted strobes against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    ev_t act;
    act = '{pr: key_press, rl: key_release, rp: key_repeat};
    if (exp_sb.num() > 0) begin
      void'(exp_sb.first(k));
      if (k < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event cyc=%0d: got none expected %h", k, exp_sb[k]);
        exp_sb.delete(k);
      end
    end
    if (exp_sb.exists(cyc)) begin
      checks++;
      if (act !== exp_sb[cyc]) begin
        errors++;
        $display("FAIL strobe cyc=%0d: got %h expected %h", cyc, act, exp_sb[cyc]);
      end
      exp_sb.delete(cyc);
    end else if (act !== '0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe cyc=%0d: got %h expected 000", cyc, act);
    end
  end

  // Press channels in mask m now, release the raw input n cycles later.
  task automatic hold(input logic [3:0] m, input int n);
    int c0, pc, rc;
    c0 = cyc;
    keyBounce = keyBounce & ~m;
    pc = c0 + Lat;
    rc = c0 + n + Lat;
    push(pc, m, 4'h0, 4'h0);
    push(rc, 4'h0, m, 4'h0);
    for (int r = pc + Delay; r < rc; r += Period) push(r, 4'h0, 4'h0, m);
    repeat (n) @(negedge clk);
    chk("held_state", key_state & m, m);
    keyBounce = keyBounce | m;
    repeat (Lat + 2) @(negedge clk);
    chk("released_state", key_state & m, 4'h0);
  endtask

  initial begin
    int c0;
    rst       = 1'b1;
    keyBounce = 4'hF;
    repeat (2) @(negedge clk);
    chk("reset_state", key_state, 4'h0);
    rst = 1'b0;

    // Idle: no strobes for 50 cycles.
    repeat (50) @(negedge clk);
    chk("idle_state", key_state, 4'h0);

    // Long hold on ch0 with several repeats, then release.
    hold(4'b0001, 30);
    repeat (5) @(negedge clk);

    // ch1 glitches shorter than the stability window.
    keyBounce[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      keyBounce[1] = 1'b1;
      @(negedge clk);
      keyBounce[1] = 1'b0;
      repeat (3) @(negedge clk);
    end
    keyBounce[1] = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_state", key_state, 4'h0);

    // ch2 and ch3 together, released before the first repeat.
    hold(4'b1100, 7);
    repeat (5) @(negedge clk);

    // Release lands exactly on a due repeat slot (press+14).
    hold(4'b0001, Delay + 2 * Period);
    repeat (5) @(negedge clk);

    // Reset while ch0 is in the repeating phase.
    c0 = cyc;
    keyBounce[0] = 1'b0;
    push(c0 + 6, 4'h1, 4'h0, 4'h0);
    push(c0 + 14, 4'h0, 4'h0, 4'h1);
    push(c0 + 17, 4'h0, 4'h0, 4'h1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset_state", key_state, 4'h0);
    push(c0 + 25, 4'h1, 4'h0, 4'h0);
    for (int r = c0 + 33; r <= c0 + 45; r += 3) push(r, 4'h0, 4'h0, 4'h1);
    push(c0 + 46, 4'h0, 4'h1, 4'h0);
    repeat (21) @(negedge clk);
    chk("post_reset_held", key_state, 4'h1);
    keyBounce[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_released", key_state, 4'h0);

    repeat (20) @(negedge clk);
    checks++;
    if (exp_sb.num() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending expected 0", exp_sb.num());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
